serial_addsub: RTL and testbench

- Parametrised, bit-serial adder/subtractor; successor to the single-bit combinational half-adder cell.
- Operands are loaded in parallel. One bit is processed per clock, LSB first, through a registered carry.
- Result is returned in parallel with carry, overflow and zero flags.
- Sits in the lab datapath as the shared arithmetic unit behind a start/busy/done handshake.

---
 rtl/serial_addsub_pkg.sv | 10 +
 rtl/serial_addsub_fa_cell.sv | 22 ++
 rtl/serial_addsub.sv | 136 +++++++++++++
 tb/tb_serial_addsub.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR of their carries.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    always_comb begin
        h1_s = a ^ b;
        h1_c = a & b;
        s    = h1_s ^ cin;
        h2_c = h1_s & cin;
        co   = h1_c | h2_c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: parallel load, one bit per clock LSB first through a
// registered carry, parallel result with carry/overflow/zero flags and start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               fa_s;
    logic               fa_co;

    fa_cell u_fa (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                    sa_d    = a;
                    sb_d    = b ^ {WIDTH{sub}};
                    c_d     = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = fa_co;
                sum_d = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q is the carry into the MSB at this point.
                    cout_d  = fa_co;
                    ovf_d   = c_q ^ fa_co;
                    zero_d  = (sum_d == '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: WIDTH=8 with a scoreboard, plus WIDTH=1 and WIDTH=16 directed cases.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    logic        start1 = 1'b0, sub1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [0:0]  sum1;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    serial_addsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } res8_t;

    res8_t q8[$];
    int    m_cnt = 0;

    function automatic res8_t exp8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] bx;
        logic [8:0] full;
        res8_t      r;
        bx     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + 9'(s);
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = (a[7] == bx[7]) && (full[7] != a[7]);
        r.zero = (full[7:0] == 8'h00);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Protocol model: capture at an idle edge, then WIDTH RUN cycles and one DONE cycle busy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q8.delete();
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (start8) begin
                q8.push_back(exp8(sub8, a8, b8));
                m_cnt = 9;
            end
        end else begin
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8", 32'(busy8), 32'(m_cnt != 0));
            chk("done8", 32'(done8), 32'(m_cnt == 1));
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'(done8), 32'd0);
                end else begin
                    res8_t r;
                    r = q8.pop_front();
                    chk("result8", 32'({sum8, cout8, ovf8, zero8}), 32'(r));
                end
            end
        end
    end

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~s;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_sum8", 32'(sum8), 32'h0);
        chk("rst_flags8", 32'({busy8, done8, cout8, ovf8, zero8}), 32'b00001);
        chk("rst_flags16", 32'({busy16, done16, cout16, ovf16, zero16, sum16}), 32'({5'b00001, 16'h0}));
        chk("rst_flags1", 32'({busy1, done1, cout1, ovf1, zero1, sum1}), 32'b000010);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // First op with explicit latency measurement.
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h55;
        k = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            k++;
        end while (!done8 && k < 20);
        chk("latency8", 32'(k), 32'd9);
        chk("sum_3c_55", 32'({sum8, cout8, ovf8, zero8}), 32'({8'h91, 3'b010}));
        repeat (3) @(negedge clk);

        op8(1'b0, 8'hFF, 8'h01);
        chk("sum_ff_01", 32'({sum8, cout8, ovf8, zero8}), 32'({8'h00, 3'b101}));
        op8(1'b1, 8'h10, 8'h20);
        chk("sub_10_20", 32'({sum8, cout8, ovf8, zero8}), 32'({8'hF0, 3'b000}));
        op8(1'b1, 8'h80, 8'h01);
        chk("sub_80_01", 32'({sum8, cout8, ovf8, zero8}), 32'({8'h7F, 3'b110}));

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start8 = 1'b1;
            sub8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during RUN.
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'hAA; b8 = 8'h0F;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum8", 32'(sum8), 32'h0);
        chk("midrst_flags8", 32'({busy8, done8, cout8, ovf8, zero8}), 32'b00001);
        repeat (2) @(negedge clk);
        chk("midrst_hold8", 32'({busy8, done8, sum8}), 32'h0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", 32'(q8.size()), 32'd0);
        op8(1'b0, 8'h01, 8'h01);
        chk("after_rst_01_01", 32'(sum8), 32'h02);

        // WIDTH=16.
        @(negedge clk);
        start16 = 1'b1; sub16 = 1'b0; a16 = 16'h7FFF; b16 = 16'h0001;
        k = 0;
        do begin
            @(negedge clk);
            start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
            k++;
        end while (!done16 && k < 40);
        chk("latency16", 32'(k), 32'd17);
        chk("w16_7fff_1", 32'({cout16, ovf16, zero16, sum16}), 32'({3'b010, 16'h8000}));

        // WIDTH=1.
        @(negedge clk);
        start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
            k++;
        end while (!done1 && k < 10);
        chk("latency1", 32'(k), 32'd2);
        chk("w1_1_plus_1", 32'({sum1, cout1, ovf1, zero1}), 32'b0111);
        @(negedge clk);
        chk("w1_done_pulse", 32'({done1, busy1}), 32'b00);
        start1 = 1'b1; sub1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start1 = 1'b0;
            k++;
        end while (!done1 && k < 10);
        chk("w1_0_minus_1", 32'({sum1, cout1, ovf1, zero1}), 32'b1010);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(q8.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
